// File: rtl/ma_cvxif_pkg.sv
// Shared types and constants for the CV-X-IF matrix-accelerator responder.
package ma_cvxif_pkg;

  localparam logic [6:0] OpcodeCustom0 = 7'b0001011;
  localparam logic [2:0] Funct3Setcfg  = 3'b000;
  localparam logic [2:0] Funct3Cmd     = 3'b001;
  localparam logic [2:0] Funct3Status  = 3'b010;

  typedef enum logic [1:0] {OpNone, OpSetcfg, OpCmd, OpStatus} op_e;

  typedef enum logic [1:0] {StIdle, StExec, StResp, StCmd} state_e;

  // Control part of a buffer entry; id and operands live in parameterised arrays.
  typedef struct packed {
    logic       valid;
    logic       committed;
    logic       killed;
    op_e        op;
    logic [6:0] funct7;
    logic [4:0] rd;
  } entry_t;

  typedef struct packed {
    logic [15:0] zero;
    logic [7:0]  count;
    logic [6:0]  rsvd;
    logic        busy;
  } status_t;

  function automatic logic [31:0] status_word(input logic [7:0] count, input logic busy);
    status_t s;
    s       = '0;
    s.count = count;
    s.busy  = busy;
    return s;
  endfunction

endpackage

// File: rtl/ma_cvxif_decoder.sv
// Combinational custom-0 decoder: instruction word to accept/writeback/op.
module ma_cvxif_decoder
  import ma_cvxif_pkg::*;
(
  input  logic [31:0] instr,
  output logic        accept,
  output logic        writeback,
  output op_e         op
);

  logic unused_fields;
  assign unused_fields = ^{instr[31:15], instr[11:7]};

  always_comb begin
    accept    = 1'b0;
    writeback = 1'b0;
    op        = OpNone;
    if (instr[6:0] == OpcodeCustom0) begin
      unique case (instr[14:12])
        Funct3Setcfg: begin
          accept    = 1'b1;
          writeback = 1'b1;
          op        = OpSetcfg;
        end
        Funct3Cmd: begin
          accept = 1'b1;
          op     = OpCmd;
        end
        Funct3Status: begin
          accept    = 1'b1;
          writeback = 1'b1;
          op        = OpStatus;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ma_cvxif_responder.sv
// CV-X-IF coprocessor responder: in-order buffer, commit tracking, result/command issue.
module ma_cvxif_responder
  import ma_cvxif_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned NrEntries = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [6:0]         cmd_funct7_o,
  output logic [XLEN-1:0]    cmd_op_a_o,
  output logic [XLEN-1:0]    cmd_op_b_o,
  output logic [15:0]        cfg_rows_o,
  output logic [15:0]        cfg_cols_o,
  input  logic               acc_busy_i
);

  localparam int unsigned PtrW = $clog2(NrEntries);
  localparam int unsigned CntW = PtrW + 1;

  entry_t               entries_q [NrEntries];
  logic [IdWidth-1:0]   ids_q     [NrEntries];
  logic [XLEN-1:0]      rs1_q     [NrEntries];
  logic [XLEN-1:0]      rs2_q     [NrEntries];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q, count_d;
  state_e               state_q, state_d;

  logic                 res_valid_q, res_valid_d;
  logic [IdWidth-1:0]   res_id_q, res_id_d;
  logic [4:0]           res_rd_q, res_rd_d;
  logic [XLEN-1:0]      res_data_q, res_data_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [6:0]           cmd_funct7_q, cmd_funct7_d;
  logic [XLEN-1:0]      cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
  logic [15:0]          rows_q, rows_d, cols_q, cols_d;

  logic                 dec_accept, dec_writeback;
  op_e                  dec_op;
  logic                 issue_fire, pop, same_id_issue;
  logic [NrEntries-1:0] commit_hit;
  entry_t               head_e;

  ma_cvxif_decoder u_decoder (
    .instr     (issue_instr_i),
    .accept    (dec_accept),
    .writeback (dec_writeback),
    .op        (dec_op)
  );

  assign issue_ready_o     = (count_q < CntW'(NrEntries)) && (&issue_rs_valid_i);
  assign issue_accept_o    = dec_accept;
  assign issue_writeback_o = dec_writeback;
  assign issue_fire        = issue_valid_i && issue_ready_o && dec_accept;
  assign same_id_issue     = issue_fire && (issue_id_i == commit_id_i);
  assign head_e            = entries_q[head_q];

  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < NrEntries; i++) begin
      commit_hit[i] = commit_valid_i && !same_id_issue && entries_q[i].valid &&
                      !entries_q[i].committed && (ids_q[i] == commit_id_i);
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_rd_d     = res_rd_q;
    res_data_d   = res_data_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_funct7_d = cmd_funct7_q;
    cmd_a_d      = cmd_a_q;
    cmd_b_d      = cmd_b_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    unique case (state_q)
      StIdle: begin
        if (head_e.valid && head_e.committed) begin
          if (head_e.killed) pop = 1'b1;
          else               state_d = StExec;
        end
      end
      StExec: begin
        unique case (head_e.op)
          OpSetcfg: begin
            res_valid_d = 1'b1;
            res_id_d    = ids_q[head_q];
            res_rd_d    = head_e.rd;
            res_data_d  = XLEN'({rows_q, cols_q});
            rows_d      = rs1_q[head_q][15:0];
            cols_d      = rs2_q[head_q][15:0];
            state_d     = StResp;
          end
          OpStatus: begin
            res_valid_d = 1'b1;
            res_id_d    = ids_q[head_q];
            res_rd_d    = head_e.rd;
            res_data_d  = XLEN'(status_word(8'(count_q), acc_busy_i));
            state_d     = StResp;
          end
          OpCmd: begin
            cmd_valid_d  = 1'b1;
            cmd_funct7_d = head_e.funct7;
            cmd_a_d      = rs1_q[head_q];
            cmd_b_d      = rs2_q[head_q];
            state_d      = StCmd;
          end
          default: state_d = StIdle;
        endcase
      end
      StResp: begin
        if (result_ready_i) begin
          pop         = 1'b1;
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StCmd: begin
        if (cmd_ready_i) begin
          pop         = 1'b1;
          cmd_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign count_d = count_q + CntW'(issue_fire) - CntW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrEntries; i++) begin
        entries_q[i] <= '0;
        ids_q[i]     <= '0;
        rs1_q[i]     <= '0;
        rs2_q[i]     <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_rd_q     <= '0;
      res_data_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_funct7_q <= '0;
      cmd_a_q      <= '0;
      cmd_b_q      <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_rd_q     <= res_rd_d;
      res_data_q   <= res_data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_funct7_q <= cmd_funct7_d;
      cmd_a_q      <= cmd_a_d;
      cmd_b_q      <= cmd_b_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      for (int i = 0; i < NrEntries; i++) begin
        if (commit_hit[i]) begin
          entries_q[i].committed <= 1'b1;
          entries_q[i].killed    <= commit_kill_i;
        end
      end
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + PtrW'(1);
      end
      // The tail slot is never the popped slot: an issue needs a free slot.
      if (issue_fire) begin
        entries_q[tail_q] <= '{valid: 1'b1, committed: 1'b0, killed: 1'b0, op: dec_op,
                               funct7: issue_instr_i[31:25], rd: issue_instr_i[11:7]};
        ids_q[tail_q]     <= issue_id_i;
        rs1_q[tail_q]     <= issue_rs1_i;
        rs2_q[tail_q]     <= issue_rs2_i;
        tail_q            <= tail_q + PtrW'(1);
      end
    end
  end

  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;
  assign result_we_o    = res_valid_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_funct7_o   = cmd_funct7_q;
  assign cmd_op_a_o     = cmd_a_q;
  assign cmd_op_b_o     = cmd_b_q;
  assign cfg_rows_o     = rows_q;
  assign cfg_cols_o     = cols_q;

endmodule
